// File: rtl/mul_pkg.sv
// Shared types and defaults for the arbitrated multiplier front end.
// Also holds the round-robin pick rule used by the issue stage.
package mul_pkg;

  localparam int N_DEF     = 8;
  localparam int CNT_W_DEF = 16;
  localparam int STAGES    = 2;

  typedef logic tag_t;

  localparam tag_t TAG_REQ0 = 1'b0;
  localparam tag_t TAG_REQ1 = 1'b1;
  localparam tag_t LAST_RST = TAG_REQ1;

  // Tie goes to whichever requester was not granted last.
  function automatic tag_t rr_pick(input logic v0, input logic v1, input tag_t last);
    tag_t pick;
    if (v0 && v1) begin
      pick = ~last;
    end else if (v1) begin
      pick = TAG_REQ1;
    end else begin
      pick = TAG_REQ0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/array_mult_core.sv
// Purely combinational unsigned N x N array multiplier (full 2N-bit product).
module array_mult_core #(
  parameter int N = 8
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] m
);

  // Sum of shifted partial products, one row per multiplier bit.
  always_comb begin
    m = {(2*N){1'b0}};
    for (int i = 0; i < N; i++) begin
      if (b[i]) begin
        m = m + ({{N{1'b0}}, a} << i);
      end else begin
        m = m + {(2*N){1'b0}};
      end
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Two-requester round-robin front end around one shared array multiplier.
// Issue register -> array -> product register; product returned to its issuer.
module mul_share_ctrl
  import mul_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic [2*N-1:0]   resp0_m,
  output logic             resp1_valid,
  output logic [2*N-1:0]   resp1_m,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  logic             gnt_vld_s;
  tag_t             gnt_tag_s;
  logic [N-1:0]     gnt_a_s;
  logic [N-1:0]     gnt_b_s;
  logic [2*N-1:0]   mul_m_s;

  tag_t             last_r;
  logic             s1_vld_r;
  tag_t             s1_tag_r;
  logic [N-1:0]     s1_a_r;
  logic [N-1:0]     s1_b_r;
  logic             s2_vld_r;
  logic             resp0_vld_r;
  logic             resp1_vld_r;
  logic [2*N-1:0]   s2_m_r;
  logic [CNT_W-1:0] ops_r;

  // Grant selection and operand mux; nothing is granted while reset is held.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_tag_s = TAG_REQ0;
    if (rst) begin
      gnt_vld_s = 1'b0;
    end else begin
      gnt_vld_s = req0_valid | req1_valid;
      gnt_tag_s = rr_pick(req0_valid, req1_valid, last_r);
    end
    if (gnt_tag_s == TAG_REQ1) begin
      gnt_a_s = req1_a;
      gnt_b_s = req1_b;
    end else begin
      gnt_a_s = req0_a;
      gnt_b_s = req0_b;
    end
  end

  assign req0_ready = gnt_vld_s && (gnt_tag_s == TAG_REQ0);
  assign req1_ready = gnt_vld_s && (gnt_tag_s == TAG_REQ1);

  array_mult_core #(.N(N)) u_core (
    .a (s1_a_r),
    .b (s1_b_r),
    .m (mul_m_s)
  );

  // Issue stage, product stage, fairness pointer and completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r      <= LAST_RST;
      s1_vld_r    <= 1'b0;
      s1_tag_r    <= TAG_REQ0;
      s1_a_r      <= {N{1'b0}};
      s1_b_r      <= {N{1'b0}};
      s2_vld_r    <= 1'b0;
      resp0_vld_r <= 1'b0;
      resp1_vld_r <= 1'b0;
      s2_m_r      <= {(2*N){1'b0}};
      ops_r       <= {CNT_W{1'b0}};
    end else begin
      if (gnt_vld_s) begin
        last_r   <= gnt_tag_s;
        s1_tag_r <= gnt_tag_s;
        s1_a_r   <= gnt_a_s;
        s1_b_r   <= gnt_b_s;
      end
      s1_vld_r    <= gnt_vld_s;
      s2_vld_r    <= s1_vld_r;
      resp0_vld_r <= s1_vld_r && (s1_tag_r == TAG_REQ0);
      resp1_vld_r <= s1_vld_r && (s1_tag_r == TAG_REQ1);
      s2_m_r      <= mul_m_s;
      if (s2_vld_r) begin
        ops_r <= ops_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign resp0_valid = resp0_vld_r;
  assign resp1_valid = resp1_vld_r;
  assign resp0_m     = s2_m_r;
  assign resp1_m     = s2_m_r;
  assign busy        = s1_vld_r | s2_vld_r;
  assign ops_done    = ops_r;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl: a transaction-level model predicts every
// negedge; literal expectations pin the model at key points.
module tb_mul_share_ctrl;

  localparam int N     = 8;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
  logic [2*N-1:0] resp0_m, resp1_m;
  logic [15:0] ops_done;
  logic d4_ready0, d4_ready1, d4_resp0_valid, d4_resp1_valid, d4_busy;
  logic [2*N-1:0] d4_resp0_m, d4_resp1_m;
  logic [3:0] ops_done4;

  always #5 clk = ~clk;

  mul_share_ctrl #(.N(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_m(resp0_m),
    .resp1_valid(resp1_valid), .resp1_m(resp1_m),
    .busy(busy), .ops_done(ops_done)
  );

  mul_share_ctrl #(.N(N), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(d4_ready0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(d4_ready1),
    .resp0_valid(d4_resp0_valid), .resp0_m(d4_resp0_m),
    .resp1_valid(d4_resp1_valid), .resp1_m(d4_resp1_m),
    .busy(d4_busy), .ops_done(ops_done4)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model state: per-edge expectations of what is visible after that edge.
  bit          m_resp[DEPTH];
  bit          m_tag[DEPTH];
  logic [15:0] m_prod[DEPTH];
  bit          m_issue[DEPTH];
  int          cyc = 0;
  bit          m_last = 1'b1;
  int unsigned m_ops = 0;

  initial begin : model
    bit g;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst && (req0_valid || req1_valid)) begin
        g = (req0_valid && req1_valid) ? !m_last : req1_valid;
        m_last = g;
        m_issue[cyc] = 1'b1;
        m_resp[cyc+1] = 1'b1;
        m_tag[cyc+1] = g;
        m_prod[cyc+1] = g ? (16'(req1_a) * 16'(req1_b)) : (16'(req0_a) * 16'(req0_b));
      end
    end
  end

  initial begin : compare
    int e;
    bit er0, er1;
    forever begin
      @(negedge clk);
      e = cyc;
      if (rst) begin
        m_last = 1'b1;
        m_ops = 0;
        m_resp[e] = 1'b0;
        m_resp[e+1] = 1'b0;
        m_issue[e] = 1'b0;
      end
      er0 = !rst && req0_valid && (!req1_valid || m_last);
      er1 = !rst && req1_valid && (!req0_valid || !m_last);
      chk("req0_ready", req0_ready, er0);
      chk("req1_ready", req1_ready, er1);
      chk("resp0_valid", resp0_valid, m_resp[e] && !m_tag[e]);
      chk("resp1_valid", resp1_valid, m_resp[e] && m_tag[e]);
      if (m_resp[e]) begin
        chk("resp_m", m_tag[e] ? resp1_m : resp0_m, m_prod[e]);
      end
      if (rst) begin
        chk("resp0_m_rst", resp0_m, 32'h0);
        chk("resp1_m_rst", resp1_m, 32'h0);
      end
      chk("busy", busy, m_issue[e] || m_resp[e]);
      chk("ops_done", ops_done, m_ops % 65536);
      chk("ops_done4", ops_done4, m_ops % 16);
      if (m_resp[e]) m_ops++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v0, input logic [7:0] a0, input logic [7:0] b0,
                       input bit v1, input logic [7:0] a1, input logic [7:0] b1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] pa, pb;
    do_reset();

    // single request
    drive(1, 8'h80, 8'h80, 0, 8'h0, 8'h0);
    #1 chk("t1_ready0", req0_ready, 1);
    step();
    drive(0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
    step();
    chk("t1_resp0_valid", resp0_valid, 1);
    chk("t1_resp0_m", resp0_m, 32'h4000);
    chk("t1_resp1_valid", resp1_valid, 0);
    step();
    chk("t1_ops_done", ops_done, 1);
    chk("t1_resp0_gone", resp0_valid, 0);

    // corners on requester 1
    drive(0, 8'h0, 8'h0, 1, 8'hFF, 8'hFF);
    step();
    drive(0, 8'h0, 8'h0, 1, 8'h00, 8'hFF);
    step();
    chk("ff_resp1_valid", resp1_valid, 1);
    chk("ff_resp1_m", resp1_m, 32'hFE01);
    drive(0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
    step();
    chk("zero_resp1_m", resp1_m, 32'h0);
    step();
    step();

    // power-of-two sweep
    do_reset();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        pa = 8'(1 << i);
        pb = 8'(1 << j);
        drive(1, pa, pb, 0, 8'h0, 8'h0);
        step();
      end
    end
    drive(0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
    step(); step(); step();
    chk("sweep_ops_done", ops_done, 64);
    chk("sweep_ops_done4", ops_done4, 0);

    // contention
    do_reset();
    drive(1, 8'd3, 8'd5, 1, 8'd7, 8'd9);
    #1 chk("tie_first_ready0", req0_ready, 1);
    chk("tie_first_ready1", req1_ready, 0);
    step();
    chk("tie_then_ready1", req1_ready, 1);
    step();
    chk("tie_resp0_m", resp0_m, 32'd15);
    step();
    chk("tie_resp1_m", resp1_m, 32'd63);
    chk("tie_resp1_valid", resp1_valid, 1);
    repeat (8) step();
    drive(0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
    step(); step(); step();

    // hold and stall: req1 alone, then req0 joins
    drive(0, 8'h0, 8'h0, 1, 8'd2, 8'd3);
    step(); step(); step();
    drive(1, 8'd4, 8'd5, 1, 8'd2, 8'd3);
    #1 chk("join_ready0", req0_ready, 1);
    step();
    chk("join_ready1", req1_ready, 1);
    step();
    drive(0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
    step(); step(); step();
    drive(1, 8'd4, 8'd5, 1, 8'd2, 8'd3);
    #1 chk("idle_keeps_last", req0_ready, 1);
    step();
    drive(0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
    step(); step(); step();

    // reset mid-flight
    drive(1, 8'd6, 8'd7, 0, 8'h0, 8'h0);
    step();
    drive(0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
    step();
    rst = 1'b1;
    #1 chk("mid_busy", busy, 0);
    chk("mid_resp0_valid", resp0_valid, 0);
    chk("mid_ops_done", ops_done, 0);
    step();
    chk("mid_no_pulse", resp0_valid, 0);
    rst = 1'b0;
    drive(1, 8'd1, 8'd2, 1, 8'd3, 8'd4);
    #1 chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 0);
    step();
    drive(0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
    step(); step(); step();

    // counter wrap on the 4-bit instance
    do_reset();
    repeat (17) begin
      drive(1, 8'd1, 8'd1, 0, 8'h0, 8'h0);
      step();
    end
    drive(0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
    step(); step(); step();
    chk("wrap_ops_done4", ops_done4, 1);
    chk("wrap_ops_done", ops_done, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Sequenced, arbitrated front end for the team's N×N combinational array multiplier. Two requesters share one multiplier instance through a valid/ready handshake; a round-robin arbiter grants one operand pair per cycle, operands and product are registered around the array (2-stage pipeline), and the product is returned to the requester that issued it. It sits between the multiplier datapath and the blocks that need products, replacing direct wiring of the multiplier to a single source.

## Interface
- N, default 8: operand width; product width is 2N.
- CNT_W, default 16: width of the completed-operation counter.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a, req0_b  in  N each  requester 0 operands (unsigned)
- req0_ready  out  1  requester 0 pair accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same as above for requester 1
- resp0_valid  out  1  one-cycle pulse, resp0_m holds requester 0's product
- resp0_m  out  2N  product for requester 0
- resp1_valid, resp1_m  same for requester 1
- busy  out  1  any operation in flight (stage 1 or 2 occupied)
- ops_done  out  CNT_W  count of completed products, wraps modulo 2^CNT_W

## Operation
- Handshake: a pair transfers when reqX_valid && reqX_ready at a rising edge. reqX_ready is combinational from valids and priority pointer; at most one ready high per cycle. Requester must hold valid/a/b stable until ready.
- Arbitration: round-robin, 1-bit pointer `last`. Only one valid → grant it. Both valid → grant the one not equal to `last`. After a grant, `last` = granted index. Reset value of `last` = 1, so requester 0 wins the first tie.
- Stage 1 (issue): on grant, register a, b, requester tag, s1_valid=1; otherwise s1_valid=0.
- Stage 2 (product): every cycle register m = s1_a*s1_b from the array instance, tag and s2_valid = s1_valid.
- Response: respX_valid = s2_valid && (s2_tag == X); respX_m = s2_m (resp of other requester drives its m but valid low). No response backpressure: requesters must take the product on the valid pulse.
- ops_done increments by 1 on each cycle with s2_valid=1; 2^CNT_W−1 → 0.
- busy = s1_valid || s2_valid.
- Arithmetic: unsigned, full 2N-bit product, no truncation or saturation.
- Reset (asserted any time, including mid-operation): all outputs 0 immediately (readies, resp valids, products, busy, ops_done), pipeline valids cleared, in-flight products discarded with no response, `last`=1. Readies stay 0 while rst is high.

## Timing
- Throughput: one product per cycle, sustained with either or both requesters streaming.
- Latency: transfer at edge k → respX_valid high during cycle k+2 (sampled at edge k+2).
- Back-to-back: both requesters permanently valid → grants alternate 0,1,0,1…; responses alternate with the same order, 2 cycles later.
- No starvation: a waiting requester is granted within 2 cycles.
- Fairness pointer updates only on an actual grant; idle cycles do not change it.

## Structure
- Shared package mul_pkg: N default, CNT_W default, tag type (1-bit requester id), localparams for stage count (2).
- One sub-module: array_mult_core #(.N(N)) (a, b, m), purely combinational unsigned array multiplier, instanced once between stage 1 and stage 2 registers. Arbiter logic stays inline.

## Test plan
- Reset then single request: req0 a=0x80, b=0x80 → req0_ready same cycle, resp0_valid 2 cycles later with resp0_m=0x4000, ops_done=1, resp1_valid never high.
- Corners: req1 a=0xFF,b=0xFF → 0xFE01; a=0x00,b=0xFF → 0x0000; sweep a=2^i, b=2^j for i,j in 0..7 → m=2^(i+j) each, one per cycle, ops_done=64.
- Contention: both valid continuously with req0 (3,5), req1 (7,9) → first grant to 0, alternating thereafter; resp0_m=15, resp1_m=63 on alternating cycles, no gaps.
- Hold and stall: req1 valid alone for 3 cycles, then req0 joins → req0 granted within 2 cycles; `last` unchanged across idle cycles.
- Reset mid-flight: grant at edge k, assert rst before edge k+2 → no response pulse, busy=0, ops_done=0; after release, first tie goes to requester 0.
- Counter wrap: CNT_W=4, issue 17 products → ops_done reads 1.
